half_adder_beh_sync: RTL and testbench

- Bit-parallel half adder: sum = a XOR b and c_out = a AND b, computed per bit.
- Combinational outputs are available immediately, independent of clock and reset, so the block also works as a plain combinational primitive.
- An optional registered copy of the outputs, with a valid flag and a saturating carry-event counter, serves pipelined datapaths and debug.
- Sits at the leaf level of the arithmetic library; it is the building block for full adders and incrementers.

---
 rtl/half_adder_beh_sync_pkg.sv | 7 +
 rtl/half_adder_cell.sv | 10 +
 rtl/half_adder_beh_sync.sv | 49 ++++
 tb/tb_half_adder_beh_sync.sv | 124 ++++++++++++
 4 files changed

// File: rtl/half_adder_beh_sync_pkg.sv
// half_adder_beh_sync_pkg: default slice count and counter saturation helper
package half_adder_beh_sync_pkg;
  localparam int HA_WIDTH = 1;
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: 1-bit sum/carry (ports: a, b in; sum, c_out out)
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic c_out
);
  assign sum = a ^ b;
  assign c_out = a & b;
endmodule

// File: rtl/half_adder_beh_sync.sv
// half_adder_beh_sync: WIDTH-bit half adder with combinational sum/c_out, registered sum_q/c_out_q/out_valid (in_valid-qualified) and a saturating carry_cnt; clk, async active-high rst
module half_adder_beh_sync
  import half_adder_beh_sync_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] c_out_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  logic [WIDTH-1:0] w_sum, w_c;
  logic [WIDTH-1:0] r_sum, r_c;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    half_adder_cell u_cell (.a(a[g]), .b(b[g]), .sum(w_sum[g]), .c_out(w_c[g]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum <= w_sum;
        r_c   <= w_c;
        if (|w_c && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign sum       = w_sum;
  assign c_out     = w_c;
  assign sum_q     = r_sum;
  assign c_out_q   = r_c;
  assign out_valid = r_valid;
  assign carry_cnt = r_cnt;
endmodule

// File: tb/tb_half_adder_beh_sync.sv
// tb_half_adder_beh_sync: directed checks of a 1-bit default instance and a 4-bit instance with a 2-bit counter
module tb_half_adder_beh_sync;
  logic       clk = 1'b0, run = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       s1, c1, sq1, cq1, v1;
  logic [7:0] n1;
  logic [3:0] s4, c4, sq4, cq4;
  logic       v4;
  logic [1:0] n4;
  int errors = 0, checks = 0;
  typedef struct {
    logic [3:0] a, b, s, c;
  } vec_t;
  vec_t vecs [6];
  half_adder_beh_sync u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
    .sum(s1), .c_out(c1), .sum_q(sq1), .c_out_q(cq1), .out_valid(v1), .carry_cnt(n1)
  );
  half_adder_beh_sync #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(in_valid),
    .sum(s4), .c_out(c4), .sum_q(sq4), .c_out_q(cq4), .out_valid(v4), .carry_cnt(n4)
  );
  always #5 if (run) clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] a, input logic [3:0] b);
    a4 = a;
    b4 = b;
    a1 = a[0];
    b1 = b[0];
  endtask
  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1010, 4'b0011, 4'b1001, 4'b0010};
    vecs[2] = '{4'b0101, 4'b1100, 4'b1001, 4'b0100};
    vecs[3] = '{4'b1111, 4'b0101, 4'b1010, 4'b0101};
    vecs[4] = '{4'b1100, 4'b1010, 4'b0110, 4'b1000};
    vecs[5] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
    rst = 1'b1;
    #10;
    chk("rst sum_q", sq1, 0);
    chk("rst c_out_q", cq1, 0);
    chk("rst out_valid", v1, 0);
    chk("rst carry_cnt", n1, 0);
    chk("rst carry_cnt w4", n4, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].b);
      #100;
      chk($sformatf("comb1 sum v%0d", i), s1, vecs[i].s[0]);
      chk($sformatf("comb1 c_out v%0d", i), c1, vecs[i].c[0]);
      chk($sformatf("comb4 sum v%0d", i), s4, vecs[i].s);
      chk($sformatf("comb4 c_out v%0d", i), c4, vecs[i].c);
    end
    chk("no clock out_valid", v1, 0);
    run = 1'b1;
    drive(4'b1100, 4'b1010);
    a1 = 1'b1;
    b1 = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("cap1 sum_q", sq1, 0);
    chk("cap1 c_out_q", cq1, 1);
    chk("cap1 out_valid", v1, 1);
    chk("cap1 carry_cnt", n1, 1);
    chk("cap4 sum_q", sq4, 4'b0110);
    chk("cap4 c_out_q", cq4, 4'b1000);
    chk("cap4 carry_cnt", n4, 1);
    in_valid = 1'b0;
    drive(4'b0000, 4'b0000);
    tick();
    chk("idle out_valid", v1, 0);
    chk("idle hold sum_q", sq1, 0);
    chk("idle hold c_out_q", cq1, 1);
    chk("idle hold4 sum_q", sq4, 4'b0110);
    chk("idle hold4 c_out_q", cq4, 4'b1000);
    chk("idle carry_cnt", n1, 1);
    in_valid = 1'b1;
    tick();
    chk("zero out_valid", v1, 1);
    chk("zero c_out_q", cq1, 0);
    chk("zero carry_cnt", n1, 1);
    drive(4'b0011, 4'b0000);
    tick();
    chk("10 sum_q", sq1, 1);
    chk("10 carry_cnt", n1, 1);
    chk("10 sum_q w4", sq4, 4'b0011);
    chk("10 carry_cnt w4", n4, 1);
    #3;
    drive(4'b1111, 4'b1111);
    rst = 1'b1;
    #1;
    chk("midrst sum_q", sq1, 0);
    chk("midrst out_valid", v1, 0);
    chk("midrst carry_cnt w4", n4, 0);
    chk("midrst sum_q w4", sq4, 0);
    chk("midrst comb sum", s1, 0);
    chk("midrst comb c_out", c1, 1);
    tick();
    chk("held rst out_valid", v4, 0);
    chk("held rst c_out_q", cq4, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat cnt w4 s%0d", i), n4, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat cnt w1 s%0d", i), n1, i + 1);
    end
    chk("sat c_out_q w4", cq4, 4'b1111);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
